// File: rtl/word_packer_pkg.sv
// Shared types and sizing helpers for the word packer.
// Optional frame counter is enabled by defining WORD_PACKER_FRAME_CNT_EN.
package word_packer_pkg;

    // FILL collects words; WAIT holds a complete frame until the output register frees up
    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Width of the word counter for a frame of n_words words
    function automatic int cnt_width(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

    // Width of a packed frame
    function automatic int frame_width(input int n_words, input int nb_data);
        return n_words * nb_data;
    endfunction

endpackage

// File: rtl/word_packer_out_reg.sv
// Output frame register with valid/ready handshake.
// With WORD_PACKER_FRAME_CNT_EN defined it also counts consumed frames.
module word_packer_out_reg #(
    parameter int FW = 128
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_load,
    input  logic [FW-1:0] i_frame,
    input  logic          i_ready,
    output logic          o_can_load,
    output logic [FW-1:0] o_data,
`ifdef WORD_PACKER_FRAME_CNT_EN
    output logic [15:0]   o_frame_cnt,
`endif
    output logic          o_valid
);

    logic [FW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          drain;

    assign drain      = valid_q & i_ready;
    assign o_can_load = ~valid_q | i_ready;
    assign o_data     = data_q;
    assign o_valid    = valid_q;

    // Load a new frame, or clear valid once the consumer has taken the current one
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        data_d  = data_q;
        valid_d = valid_q;
        if (i_load) begin
            data_d  = i_frame;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Output register state
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef WORD_PACKER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Count consumed frames, wrapping naturally at 16 bits
    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(drain);
    end

    // Frame counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: rtl/word_packer.sv
// Packs a stream of signed words into frames of N_WORDS words, word k at
// bits [(k+1)*NB_DATA-1 -: NB_DATA], so words 2j/2j+1 form multiplier pair j.
// Optional o_frame_cnt port is enabled by defining WORD_PACKER_FRAME_CNT_EN.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int N_WORDS = 16,
    parameter int NB_DATA = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NB_DATA-1:0]         i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_clear,
    output logic [N_WORDS*NB_DATA-1:0] o_data,
    output logic                       o_valid,
`ifdef WORD_PACKER_FRAME_CNT_EN
    output logic [15:0]                o_frame_cnt,
`endif
    input  logic                       i_ready
);

    localparam int CNT_W = cnt_width(N_WORDS);
    localparam int FW    = frame_width(N_WORDS, NB_DATA);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic [FW-1:0]     frame_next;
    logic [FW-1:0]     load_frame;
    logic              load;
    logic              can_load;
    logic              last_word;

    assign last_word = (cnt_q == CNT_W'(N_WORDS - 1));

    // Fill buffer with the incoming word dropped into its slot
    always_comb begin
        frame_next = fill_q;
        frame_next[cnt_q*NB_DATA +: NB_DATA] = i_data;
    end

    // Next-state, counter, fill buffer and handoff to the output register
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        load       = 1'b0;
        load_frame = fill_q;
        o_ready    = (state_q == FILL) & ~i_clear;

        if (i_clear) begin
            // Abort wins over an incoming word and over a pending WAIT handoff
            state_d = FILL;
            cnt_d   = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (i_valid) begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        fill_d = frame_next;
                        if (last_word) begin
                            if (can_load) begin
                                load       = 1'b1;
                                load_frame = frame_next;
                            end else begin
                                state_d = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (can_load) begin
                        load    = 1'b1;
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // FSM state, word counter and fill buffer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    word_packer_out_reg #(
        .FW (FW)
    ) u_out_reg (
        .clock       (clock),
        .reset       (reset),
        .i_load      (load),
        .i_frame     (load_frame),
        .i_ready     (i_ready),
        .o_can_load  (can_load),
        .o_data      (o_data),
`ifdef WORD_PACKER_FRAME_CNT_EN
        .o_frame_cnt (o_frame_cnt),
`endif
        .o_valid     (o_valid)
    );

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer (N_WORDS=4, NB_DATA=8).
// Defining WORD_PACKER_FRAME_CNT_EN also checks the frame counter.
module tb_word_packer;

    localparam int N  = 4;
    localparam int NB = 8;
    localparam int FW = N * NB;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic [NB-1:0] i_data  = '0;
    logic          i_valid = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_ready;
    logic          o_valid;
    logic [FW-1:0] o_data;
`ifdef WORD_PACKER_FRAME_CNT_EN
    logic [15:0]   o_frame_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    word_packer #(
        .N_WORDS (N),
        .NB_DATA (NB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_clear     (i_clear),
        .o_data      (o_data),
        .o_valid     (o_valid),
`ifdef WORD_PACKER_FRAME_CNT_EN
        .o_frame_cnt (o_frame_cnt),
`endif
        .i_ready     (i_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words collected so far, and complete frames not yet consumed
    // (front = frame in the output register, a second entry = frame held back).
    logic [NB-1:0] part_q[$];
    logic [FW-1:0] frames_q[$];
    logic [FW-1:0] last_data = '0;
    int unsigned   m_cnt = 0;
    bit            m_rdy, m_take;
    logic [FW-1:0] m_frame;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            part_q.delete();
            frames_q.delete();
            last_data = '0;
            m_cnt     = 0;
        end else begin
            m_rdy  = !i_clear && frames_q.size() < 2;
            m_take = frames_q.size() > 0 && i_ready;
            if (i_clear && frames_q.size() == 2) frames_q.delete(1);
            if (m_take) begin
                last_data = frames_q.pop_front();
                m_cnt++;
            end
            if (i_valid && m_rdy) begin
                part_q.push_back(i_data);
                if (part_q.size() == N) begin
                    m_frame = '0;
                    for (int k = 0; k < N; k++) m_frame[k*NB +: NB] = part_q[k];
                    frames_q.push_back(m_frame);
                    part_q.delete();
                end
            end
            if (i_clear) part_q.delete();
        end
    end

    // Compare DUT outputs against the model every cycle, away from the rising edge
    always @(negedge clock) begin
        if (!reset) begin
            check("rst_valid", 64'(o_valid), 64'(0));
            check("rst_data",  64'(o_data),  64'(0));
        end else begin
            check("ready", 64'(o_ready), 64'(!i_clear && frames_q.size() < 2));
            check("valid", 64'(o_valid), 64'(frames_q.size() > 0));
            check("data",  64'(o_data),  64'((frames_q.size() > 0) ? frames_q[0] : last_data));
`ifdef WORD_PACKER_FRAME_CNT_EN
            check("frame_cnt", 64'(o_frame_cnt), 64'(m_cnt[15:0]));
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset and release
        repeat (3) tick();
        reset = 1'b1;
        check("post_rst_ready", 64'(o_ready), 64'(1));
        check("post_rst_valid", 64'(o_valid), 64'(0));

        // Single frame, latency one cycle after the last accept
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            i_data  = NB'(k + 1);
            if (k == 3) check("t1_valid_early", 64'(o_valid), 64'(0));
            tick();
        end
        check("t1_valid", 64'(o_valid), 64'(1));
        check("t1_data",  64'(o_data),  64'h04030201);
        i_valid = 1'b0;
        tick();
        check("t1_drained", 64'(o_valid), 64'(0));

        // Back-to-back frames with no bubbles
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1;
            i_data  = NB'(8'h10 + k);
            check("t2_ready", 64'(o_ready), 64'(1));
            tick();
            if (k == 3) check("t2_frame0", 64'(o_data), 64'h13121110);
            if (k == 5) check("t2_gap",    64'(o_valid), 64'(0));
            if (k == 7) check("t2_frame1", 64'(o_data), 64'h17161514);
        end
        i_valid = 1'b0;
        tick();
`ifdef WORD_PACKER_FRAME_CNT_EN
        check("cnt_three", 64'(o_frame_cnt), 64'(3));
`endif

        // Backpressure: second frame waits, block stalls, both delivered in order
        i_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_valid = 1'b1;
            i_data  = NB'(8'h20 + k);
            tick();
        end
        i_data = 8'h99;
        check("t3_ready_wait", 64'(o_ready), 64'(0));
        check("t3_hold_data",  64'(o_data),  64'h23222120);
        repeat (2) tick();
        check("t3_hold_valid", 64'(o_valid), 64'(1));
        check("t3_hold_data2", 64'(o_data),  64'h23222120);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("t3_frame1_valid", 64'(o_valid), 64'(1));
        check("t3_frame1_data",  64'(o_data),  64'h27262524);
        check("t3_ready_back",   64'(o_ready), 64'(1));
        tick();
        check("t3_drained", 64'(o_valid), 64'(0));

        // Clear drops the partial frame and beats a simultaneous word
        for (int k = 0; k < 2; k++) begin
            i_valid = 1'b1;
            i_data  = NB'(8'h11 * (k + 1));
            tick();
        end
        i_clear = 1'b1;
        i_data  = 8'h33;
        #1;
        check("t4_clear_ready", 64'(o_ready), 64'(0));
        tick();
        i_clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_data = NB'(8'hA0 + k);
            tick();
        end
        check("t4_data", 64'(o_data), 64'hA3A2A1A0);
        i_valid = 1'b0;
        tick();
`ifdef WORD_PACKER_FRAME_CNT_EN
        check("cnt_six", 64'(o_frame_cnt), 64'(6));
`endif

        // Reset mid-frame discards partial words
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = NB'(8'h51 + k);
            tick();
        end
        i_valid = 1'b0;
        reset   = 1'b0;
        #1;
        check("t5_rst_valid", 64'(o_valid), 64'(0));
        check("t5_rst_data",  64'(o_data),  64'(0));
        repeat (2) tick();
        reset = 1'b1;
        check("t5_ready", 64'(o_ready), 64'(1));
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            i_data  = NB'(8'hC0 + k);
            tick();
        end
        check("t5_data", 64'(o_data), 64'hC3C2C1C0);
        i_valid = 1'b0;
        tick();

        // Randomized traffic with bursts of backpressure and occasional clears
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) i_ready = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 7) == 0) i_ready = ~i_ready;
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = NB'($urandom);
            i_clear = ($urandom_range(0, 40) == 0);
            tick();
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        repeat (6) tick();
        check("final_idle", 64'(o_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter N_WORDS, default 16: words per frame; power of two, >= 4.
REQ-002 SHALL have parameter NB_DATA, default 8: bits per signed word.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_data, input, NB_DATA bits: upstream word.
REQ-006 SHALL have port i_valid, input, 1 bit: i_data valid.
REQ-007 SHALL have port o_ready, output, 1 bit: block accepts a word this cycle.
REQ-008 SHALL have port i_clear, input, 1 bit: synchronous abort of the partial frame.
REQ-009 SHALL have port o_data, output, N_WORDS*NB_DATA bits: packed frame for the multiply/adder-tree stage.
REQ-010 SHALL have port o_valid, output, 1 bit: o_data holds a complete frame.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream consumes o_data this cycle.

Function
REQ-012 SHALL accept a word only when i_valid=1 and o_ready=1 in the same cycle.
REQ-013 SHALL write accepted word k (0-based, in arrival order) to fill-buffer bits [(k+1)*NB_DATA-1 -: NB_DATA], so that words 2j and 2j+1 form multiplier pair j.
REQ-014 SHALL use a word counter of width $clog2(N_WORDS): increment on accept, wrap to 0 after word N_WORDS-1.
REQ-015 SHALL implement a two-state FSM: FILL (o_ready=1 unless i_clear=1) and WAIT (o_ready=0).
REQ-016 SHALL, on accepting word N_WORDS-1 in FILL, copy the frame into the output register if the register is empty or drained (o_valid & i_ready) in that cycle, and SHALL otherwise go to WAIT.
REQ-017 SHALL, in WAIT, move the fill buffer into the output register and return to FILL in the cycle the output register is drained.
REQ-018 SHALL assert o_valid in the cycle after the frame enters the output register (latency 1 cycle from the last accept), and SHALL hold o_data and o_valid stable until i_ready=1.
REQ-019 SHALL sustain one word per cycle with no bubbles while i_ready is held at 1.
REQ-020 SHALL, when i_clear=1, drive o_ready=0, zero the counter, force FILL, and drop the partial or waiting frame; the output register SHALL be unaffected.
REQ-021 SHALL give i_clear priority over a simultaneous i_valid and over a WAIT-to-output transfer.

Reset
REQ-022 SHALL, while reset=0, immediately set FSM=FILL, counter=0, o_valid=0, o_data=0 and the fill buffer to 0; o_ready SHALL be 1 from the first cycle after reset is released.
REQ-023 SHALL discard any in-flight frame when reset is asserted mid-frame, with no partial data appearing after release.

Configuration
REQ-024 SHALL, when macro WORD_PACKER_FRAME_CNT_EN is defined, add output o_frame_cnt, 16 bits, reset 0, incremented on each o_valid & i_ready and wrapping 0xFFFF->0.
REQ-025 SHALL, without WORD_PACKER_FRAME_CNT_EN, have neither the port nor its logic.

Structure
REQ-026 SHALL place the FSM state typedef (FILL, WAIT) and the counter-width and frame-width constant functions in package word_packer_pkg.
REQ-027 SHALL place the output register and its valid/ready logic in one sub-module, word_packer_out_reg.

Verification (N_WORDS=4, NB_DATA=8)
REQ-028 SHALL cover: stream 0x01,0x02,0x03,0x04, i_ready=1 -> o_data=0x04030201, o_valid one cycle after the 4th accept.
REQ-029 SHALL cover: 8 back-to-back words, i_ready=1 -> o_ready constantly 1, two frames on consecutive 4-cycle boundaries.
REQ-030 SHALL cover: i_ready=0 for 10 cycles while 8 words are offered -> first frame held stable, o_ready=0 after the 8th accept, both frames delivered in order once i_ready=1.
REQ-031 SHALL cover: i_clear asserted with i_valid after 2 words -> those words dropped; the next 4 words 0xA0..0xA3 give o_data=0xA3A2A1A0.
REQ-032 SHALL cover: reset=0 asserted after 3 words -> o_valid=0 and o_data=0 immediately, and the next frame packs correctly from word 0.
REQ-033 SHALL cover, with WORD_PACKER_FRAME_CNT_EN: 3 consumed frames -> o_frame_cnt=3; preload 0xFFFF plus one frame -> 0.
